// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 (load/store unit) has priority,
// and a hold counter guarantees that port 1 (DMA/debug) is served after MAX_HOLD consecutive losses.
module dmem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 20,
    parameter int MAX_HOLD       = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_data_out,

    output logic [2:0]            hold_cnt
);

    logic                  hold_full;
    logic                  any_gnt;
    logic                  sel_we;
    logic                  sel_in_range;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign hold_full = (hold_cnt == 3'(MAX_HOLD));

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (p0_req && !(p1_req && hold_full)) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

    assign any_gnt      = p0_gnt | p1_gnt;
    assign sel_we       = p1_gnt ? p1_we    : p0_we;
    assign sel_addr     = p1_gnt ? p1_addr  : p0_addr;
    assign sel_wdata    = p1_gnt ? p1_wdata : p0_wdata;
    assign sel_in_range = ((sel_addr >> MEM_ADDR_WIDTH) == '0);

    // Out-of-range accesses never reach the memory; idle cycles replay the last address/data.
    always_comb begin
        mem_addr    = any_gnt ? sel_addr  : addr_q;
        mem_data_in = any_gnt ? sel_wdata : wdata_q;
        mem_write   = any_gnt && sel_we && sel_in_range;
        mem_read    = !(any_gnt && !sel_we && sel_in_range);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
            hold_cnt  <= 3'd0;
        end else begin
            if (any_gnt) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end

            // Reads and blocked writes answer one cycle after the grant; good writes stay silent.
            p0_rvalid <= p0_gnt && (!sel_we || !sel_in_range);
            p0_err    <= p0_gnt && !sel_in_range;
            if (p0_gnt && !sel_we) begin
                p0_rdata <= sel_in_range ? mem_data_out : '0;
            end

            p1_rvalid <= p1_gnt && (!sel_we || !sel_in_range);
            p1_err    <= p1_gnt && !sel_in_range;
            if (p1_gnt && !sel_we) begin
                p1_rdata <= sel_in_range ? mem_data_out : '0;
            end

            if (!p1_req || p1_gnt) begin
                hold_cnt <= 3'd0;
            end else if (p0_gnt && !hold_full) begin
                hold_cnt <= hold_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory plus a reference model of grants, responses,
// hold count and memory contents, driven by directed steps followed by random traffic.
module tb_dmem_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int MEM_AW   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p0_gnt, p0_rvalid, p0_err;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p1_rdata;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_write, mem_read;
    logic [2:0]  hold_cnt;

    dmem_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_WIDTH(MEM_AW), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_read(mem_read), .mem_data_out(mem_data_out), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    // Environment memory: 256 words; output is garbage unless mem_read is low.
    logic [31:0] env_mem [256];
    assign mem_data_out = mem_read ? 32'hBAD0_BAD0 : env_mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_write) env_mem[mem_addr[7:0]] <= mem_data_in;

    // Reference model state
    logic [31:0] m_mem [256];
    int          m_hold;
    logic [31:0] m_last_addr, m_last_wdata;
    logic [31:0] m_rdata  [2];
    logic        m_rvalid [2];
    logic        m_err    [2];
    bit          last_g0, last_g1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0;
        m_last_addr = '0;
        m_last_wdata = '0;
        for (int p = 0; p < 2; p++) begin
            m_rdata[p] = '0;
            m_rvalid[p] = 1'b0;
            m_err[p] = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".p0_rvalid"}, 32'(p0_rvalid), 32'(m_rvalid[0]));
        check({tag, ".p0_err"},    32'(p0_err),    32'(m_err[0]));
        check({tag, ".p0_rdata"},  p0_rdata,       m_rdata[0]);
        check({tag, ".p1_rvalid"}, 32'(p1_rvalid), 32'(m_rvalid[1]));
        check({tag, ".p1_err"},    32'(p1_err),    32'(m_err[1]));
        check({tag, ".p1_rdata"},  p1_rdata,       m_rdata[1]);
        check({tag, ".hold_cnt"},  32'(hold_cnt),  32'(m_hold));
    endtask

    // One clock cycle: called just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        bit g0, g1, g, w, inr;
        logic [31:0] a, d;
        #1;
        g0  = p0_req && !(p1_req && m_hold == MAX_HOLD);
        g1  = p1_req && !g0;
        g   = g0 || g1;
        w   = g1 ? p1_we : p0_we;
        a   = g1 ? p1_addr : p0_addr;
        d   = g1 ? p1_wdata : p0_wdata;
        inr = (a >> MEM_AW) == 0;
        check({tag, ".p0_gnt"},      32'(p0_gnt),    32'(g0));
        check({tag, ".p1_gnt"},      32'(p1_gnt),    32'(g1));
        check({tag, ".mem_write"},   32'(mem_write), 32'(g && w && inr));
        check({tag, ".mem_read"},    32'(mem_read),  32'(!(g && !w && inr)));
        check({tag, ".mem_addr"},    mem_addr,       g ? a : m_last_addr);
        check({tag, ".mem_data_in"}, mem_data_in,    g ? d : m_last_wdata);

        if (g) begin
            m_last_addr = a;
            m_last_wdata = d;
        end
        m_rvalid[0] = g0 && (!w || !inr);
        m_err[0]    = g0 && !inr;
        m_rvalid[1] = g1 && (!w || !inr);
        m_err[1]    = g1 && !inr;
        if (g0 && !w) m_rdata[0] = inr ? m_mem[a[7:0]] : '0;
        if (g1 && !w) m_rdata[1] = inr ? m_mem[a[7:0]] : '0;
        if (g && w && inr) m_mem[a[7:0]] = d;
        if (!p1_req || g1) m_hold = 0;
        else if (g0 && m_hold < MAX_HOLD) m_hold++;
        last_g0 = g0;
        last_g1 = g1;

        @(posedge clk);
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    task automatic drive(input int p, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return 32'($urandom_range(0, 255)) | (32'd1 << (MEM_AW + $urandom_range(0, 11)));
        return 32'($urandom_range(0, 255));
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 32'(i) * 32'h0101_0101 + 32'h11;
            m_mem[i]   = 32'(i) * 32'h0101_0101 + 32'h11;
        end
        model_reset();

        // Reset values
        #6;
        check("rst.p0_gnt",    32'(p0_gnt),    32'd0);
        check("rst.p1_gnt",    32'(p1_gnt),    32'd0);
        check("rst.mem_read",  32'(mem_read),  32'd1);
        check("rst.mem_write", 32'(mem_write), 32'd0);
        check("rst.mem_addr",  mem_addr,       32'd0);
        check_regs("rst");
        @(negedge clk);
        rst = 1'b0;

        // p0 write then read back
        drive(0, 1, 1, 32'h10, 32'hDEAD_BEEF);
        step("p0_wr");
        drive(0, 1, 0, 32'h10, 32'h0);
        step("p0_rd");
        drive(0, 0, 0, 32'h10, 32'h0);
        check("p0_rd.rvalid", 32'(p0_rvalid), 32'd1);
        check("p0_rd.rdata",  p0_rdata,       32'hDEAD_BEEF);
        check("p0_rd.err",    32'(p0_err),    32'd0);

        // Both ports requesting continuously: four p0 grants, then one p1 grant
        drive(0, 1, 0, 32'h10, 32'h0);
        drive(1, 1, 0, 32'h11, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("seq.p1_gnt", 32'(p1_gnt), 32'((i % 5) == 4));
            step("seq");
            check("seq.hold", 32'(hold_cnt), (i % 5) == 4 ? 32'd0 : 32'((i % 5) + 1));
        end
        drive(0, 0, 0, 32'h0, 32'h0);

        // p1 out-of-range write is blocked and answered with an error
        drive(1, 1, 1, 32'h0010_0000, 32'hCAFE_F00D);
        step("oor_wr");
        check("oor_wr.rvalid", 32'(p1_rvalid), 32'd1);
        check("oor_wr.err",    32'(p1_err),    32'd1);
        drive(1, 1, 0, 32'h0, 32'h0);
        step("oor_rd0");

        // p1 write followed directly by a p0 read of the same word
        drive(1, 1, 1, 32'h20, 32'h1234);
        step("fwd_wr");
        drive(1, 0, 0, 32'h0, 32'h0);
        drive(0, 1, 0, 32'h20, 32'h0);
        step("fwd_rd");
        check("fwd_rd.rdata", p0_rdata, 32'h1234);

        // Idle: memory released, rdata retained
        drive(0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) step("idle");
        check("idle.p0_rdata", p0_rdata, 32'h1234);

        // Reset while a read is granted
        drive(0, 1, 0, 32'h10, 32'h0);
        #2;
        check("mrst.pre_gnt", 32'(p0_gnt), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("mrst.p0_gnt",    32'(p0_gnt),    32'd0);
        check("mrst.mem_read",  32'(mem_read),  32'd1);
        check("mrst.mem_addr",  mem_addr,       32'd0);
        check("mrst.mem_data",  mem_data_in,    32'd0);
        check_regs("mrst");
        @(posedge clk);
        #1;
        check_regs("mrst_edge");
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 32'h0);
        rst = 1'b0;
        drive(0, 1, 0, 32'h20, 32'h0);
        step("post_rst");
        drive(0, 0, 0, 32'h0, 32'h0);
        step("post_rst_idle");

        // Random traffic; a requester keeps its attributes until granted
        last_g0 = 1'b1;
        last_g1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!p0_req || last_g0)
                drive(0, $urandom_range(0, 3) != 0, 1'($urandom), rand_addr(), $urandom);
            if (!p1_req || last_g1)
                drive(1, $urandom_range(0, 2) != 0, 1'($urandom), rand_addr(), $urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter in front of the single-port data memory. It shares the memory between the core load/store unit (port 0) and the DMA/debug engine (port 1).
- Port 0 has priority, but a hold counter guarantees port 1 gets service.
- Grant is combinational, so each port can issue one access per cycle. The write commits at the granting clock edge; read data returns registered one cycle later.
- Out-of-range addresses are blocked and answered with an error response.

Parameters:
- DATA_WIDTH, 32, width of all data buses.
- ADDR_WIDTH, 32, width of requester and memory address buses.
- MEM_ADDR_WIDTH, 20, implemented word-address bits. Any address with a nonzero bit at or above this index is out of range.
- MAX_HOLD, 4, maximum consecutive port-0 grants while port 1 is waiting.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- p0_req  input  1  port 0 request; held stable with its attributes until p0_gnt
- p0_we  input  1  port 0 write (1) / read (0)
- p0_addr  input  ADDR_WIDTH  port 0 word address
- p0_wdata  input  DATA_WIDTH  port 0 write data
- p0_gnt  output  1  port 0 transfer accepted this cycle
- p0_rvalid  output  1  port 0 read response valid (one-cycle pulse)
- p0_rdata  output  DATA_WIDTH  port 0 read data
- p0_err  output  1  port 0 out-of-range response, valid with p0_rvalid
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: identical set for port 1
- mem_addr  output  ADDR_WIDTH  to memory addr
- mem_data_in  output  DATA_WIDTH  to memory data_in
- mem_write  output  1  to memory mem_write
- mem_read  output  1  to memory mem_read; memory output is valid only while this is 0
- mem_data_out  input  DATA_WIDTH  memory combinational read data
- hold_cnt  output  3  current consecutive port-0 grant count while port 1 waits (debug)

Behaviour:
- Reset (async, immediate):
  - p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_write = 0.
  - mem_read = 1; p0_rdata, p1_rdata, mem_addr, mem_data_in = 0; hold_cnt = 0.
  - Grants are forced to 0 while rst is high.
- Arbitration (combinational, each cycle):
  - Only p0_req set: grant port 0.
  - Only p1_req set: grant port 1.
  - Both set: grant port 1 if hold_cnt == MAX_HOLD, else grant port 0.
  - Neither set: no grant; mem_write = 0, mem_read = 1, mem_addr/mem_data_in hold their last values.
- Access cycle for the granted port:
  - mem_addr and mem_data_in are driven from that port.
  - A transfer is defined as req && gnt.
- Range check: in_range = (addr >> MEM_ADDR_WIDTH) == 0.
- Write transfer:
  - In range: mem_write = 1, mem_read = 1. Data commits at the clock edge ending the cycle.
  - Out of range: mem_write = 0, memory is untouched, and the port gets rvalid = 1, err = 1 next cycle.
  - An in-range write produces no response.
- Read transfer:
  - mem_read = 0 and mem_write = 0 in the access cycle; mem_data_out is captured into pX_rdata at the edge.
  - pX_rvalid = 1 in the following cycle with err = 0.
  - Out of range: mem_read stays 1, rdata = 0, err = 1.
  - Latency is exactly 1 cycle from the grant edge.
- rvalid and err are single-cycle pulses. rdata holds its value until the next read response to that port.
- hold_cnt:
  - Increments (saturating at MAX_HOLD) on a port-0 grant while p1_req = 1.
  - Clears to 0 on any port-1 grant, or in any cycle with p1_req = 0.
- Back-to-back transfers are supported: one transfer per cycle overall. A port granted every cycle receives a response every cycle.
- Simultaneous new grant and response: a response for the previous access and a grant for a new access may occur in the same cycle on the same or different ports.
- Requesters must not drop req before gnt. Behaviour is undefined if the attributes change while req is held without gnt.
- Reset mid-access: a pending read response is discarded (rvalid = 0). A write whose edge coincides with rst assertion is not guaranteed.

Test Plan:
- p0 write addr 0x10 data 0xDEADBEEF, then p0 read 0x10 -> p0_gnt each cycle; p0_rvalid = 1 the cycle after the read grant, with p0_rdata = 0xDEADBEEF and p0_err = 0.
- p0_req and p1_req held high continuously, MAX_HOLD = 4 -> grant sequence p0,p0,p0,p0,p1,p0,p0,p0,p0,p1…; hold_cnt goes 0,1,2,3,4,0.
- p1 write addr 0x0010_0000 (bit 20 set) -> mem_write stays 0; next cycle p1_rvalid = 1, p1_err = 1; a subsequent read of 0x0 returns its prior contents.
- p1 write 0x20 = 0x1234 in cycle N, p0 read 0x20 in cycle N+1 -> p0_rdata = 0x1234 in cycle N+2.
- rst asserted for 1 cycle mid-stream while a read is granted -> all outputs immediately take reset values, no rvalid follows; operation resumes cleanly after release.
- Idle for 5 cycles after a read -> mem_read = 1, mem_write = 0, all gnt and rvalid = 0; p0_rdata retains its last value.
